// File: rtl/dual_issue_queue.sv
// Decoupling queue between dual-issue decode and EX: accepts up to two bundles per
// cycle, issues one or two per cycle into registered A/B slots under pairing rules.
module dual_issue_queue #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 96
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               stall,
    input  logic               EX_br,
    input  logic               ID_valid_a,
    input  logic               ID_valid_b,
    input  logic [ENTRY_W-1:0] ID_bundle_a,
    input  logic [ENTRY_W-1:0] ID_bundle_b,
    output logic               ID_ready,
    output logic               EX_valid_a,
    output logic               EX_valid_b,
    output logic [ENTRY_W-1:0] EX_bundle_a,
    output logic [ENTRY_W-1:0] EX_bundle_b
);
    localparam int PW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      head_q, tail_q;
    logic [PW:0]        count_q;
    logic               valid_a_q, valid_b_q;
    logic [ENTRY_W-1:0] bundle_a_q, bundle_b_q;

    logic [ENTRY_W-1:0] h0, h1;
    logic               raw_hazard, mem_clash, pair_ok, do_enq;
    logic [PW:0]        enq_n, deq_n;

    assign ID_ready = (count_q <= (PW+1)'(DEPTH - 2));

    assign h0 = mem_q[head_q];
    assign h1 = mem_q[head_q + PW'(1)];

    // r0 is never a real destination, so a write to it cannot create a RAW hazard.
    assign raw_hazard = h0[15] && (h0[14:10] != 5'd0) &&
                        ((h1[4:0] == h0[14:10]) || (h1[9:5] == h0[14:10]));
    assign mem_clash  = h0[16] && h1[16];
    assign pair_ok    = (count_q >= (PW+1)'(2)) && !raw_hazard && !mem_clash;

    assign do_enq = ID_ready && ID_valid_a && !EX_br;

    always_comb begin
        enq_n = '0;
        if (do_enq) enq_n = ID_valid_b ? (PW+1)'(2) : (PW+1)'(1);
        deq_n = '0;
        if (!stall && !EX_br && (count_q != '0)) deq_n = pair_ok ? (PW+1)'(2) : (PW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem_q[tail_q] <= ID_bundle_a;
            if (ID_valid_b) mem_q[tail_q + PW'(1)] <= ID_bundle_b;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_a_q  <= 1'b0;
            valid_b_q  <= 1'b0;
            bundle_a_q <= '0;
            bundle_b_q <= '0;
        end else if (EX_br) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
        end else begin
            tail_q  <= tail_q + enq_n[PW-1:0];
            head_q  <= head_q + deq_n[PW-1:0];
            count_q <= count_q + enq_n - deq_n;
            if (!stall) begin
                if (count_q == '0) begin
                    valid_a_q <= 1'b0;
                    valid_b_q <= 1'b0;
                end else begin
                    valid_a_q  <= 1'b1;
                    bundle_a_q <= h0;
                    valid_b_q  <= pair_ok;
                    if (pair_ok) bundle_b_q <= h1;
                end
            end
        end
    end

    assign EX_valid_a  = valid_a_q;
    assign EX_valid_b  = valid_b_q;
    assign EX_bundle_a = bundle_a_q;
    assign EX_bundle_b = bundle_b_q;
endmodule
